iot_monitor_multi: RTL and testbench
====================================

Name: iot_monitor_multi

Overview:
Multi-channel successor to the single 8-bit active-device monitor. Each of N_CH channels keeps its own up/down count of active IoT devices. Per-channel counts can be configured to wrap or saturate. The block also keeps a registered aggregate total, a threshold alarm with hysteresis, sticky overflow/underflow flags, and a registered per-channel readout port. It sits between the device-event front end and the status/CSR layer.

Parameters:
N_CH, 4, number of monitored channels (>=1)
WIDTH, 8, per-channel counter width
SAT_MODE, 0, 0 = wrap-around at bounds; 1 = saturate at 0 and 2^WIDTH-1
HYST, 2, alarm hysteresis in devices (< 2^TW)
THR_RST, 16, threshold value loaded at reset
Derived: SELW = max(1, clog2(N_CH)); TW = WIDTH + SELW

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
change  in  N_CH  per-channel event strobe; 0 = hold
on_off  in  N_CH  per-channel direction when change=1; 1 = up, 0 = down
thr_we  in  1  threshold write strobe
thr_data  in  TW  new threshold value
flag_clr  in  1  clears all sticky flags
rd_sel  in  SELW  channel index for readout
rd_data  out  WIDTH  registered count of channel rd_sel
total_out  out  TW  registered sum of all channel counts
alarm  out  1  high-occupancy alarm
ovf_flag  out  N_CH  sticky: channel hit an upper-bound event
udf_flag  out  N_CH  sticky: channel hit a lower-bound event

Behaviour:
- Reset: the clock is clk; reset rst is synchronous and active-high. On rst, all channel counts = 0, total_out = 0, rd_data = 0, alarm = 0, ovf_flag = 0, udf_flag = 0, threshold register = THR_RST. rst overrides every other input in the same cycle.
- Channel i, per cycle:
  - change[i]=0: count holds.
  - change[i]=1, on_off[i]=1: count+1.
  - change[i]=1, on_off[i]=0: count-1.
  - Channels are fully independent; any combination may change in the same cycle.
- Upper bound (count = 2^WIDTH-1 with an up event):
  - SAT_MODE=0: count wraps to 0.
  - SAT_MODE=1: count holds.
  - In both modes, ovf_flag[i] is set the next cycle.
- Lower bound (count = 0 with a down event):
  - SAT_MODE=0: count wraps to 2^WIDTH-1.
  - SAT_MODE=1: count holds.
  - In both modes, udf_flag[i] is set the next cycle.
- Sticky flags: cleared by flag_clr. If flag_clr coincides with a new bound event, set wins.
- total_out: registered sum of the current channel counts, zero-extended to TW. Lags the channel counts by 1 cycle (2 cycles after the change input). Never overflows, because TW is sized for the full sum.
- rd_data: registered count of channel rd_sel, 1-cycle latency from rd_sel and from the count update. rd_sel >= N_CH returns 0.
- Threshold register:
  - Written with thr_data on the cycle after thr_we=1.
  - If thr_we coincides with rst, rst wins.
- Alarm FSM, two states, evaluated on total_out and the threshold register:
  - IDLE (alarm=0) -> ALARM when total_out >= thr.
  - ALARM (alarm=1) -> IDLE when total_out + HYST < thr. The comparison is done in TW+1 bits, so no underflow at small thr.
  - alarm is the registered state output, asserted 1 cycle after the condition is met.
  - thr=0 forces ALARM after reset exit.
- Mid-operation reset returns everything to the reset values above on the next edge. No partial state survives.

Optional Feature:
PEAK_HOLD_EN
- Defined: adds output peak_out[TW-1:0] and input peak_clr.
  - peak_out holds the maximum total_out seen since rst or peak_clr, updated 1 cycle after total_out.
  - peak_clr loads the current total_out.
  - Reset value is 0.
- Undefined: the ports and register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package iot_mon_pkg: localparam helpers for SELW/TW (clog2 function), alarm state enum {ST_IDLE, ST_ALARM}, mode constants MODE_WRAP=0 and MODE_SAT=1.
- One natural sub-module: iot_chan_counter (WIDTH, SAT_MODE), containing one channel's counter and its ovf/udf event pulses. It is instantiated N_CH times in a generate loop. Aggregation, alarm FSM and readout stay in the top.

Test Plan:
- rst for 2 cycles, then idle -> all counts 0, total_out=0, alarm=0, flags 0, thr=16.
- Channel 0 up 5 cycles, channel 1 up 3 cycles concurrently -> rd_sel=0 gives 5, rd_sel=1 gives 3; total_out=8 two cycles after the last change.
- SAT_MODE=0: drive channel 2 up 256 times -> count 0, ovf_flag[2]=1. Then one down -> count 255, udf_flag[2]=1. Repeat with SAT_MODE=1 -> count holds at 255 / 0 and the flags still set.
- thr_we with thr_data=10, raise total to 10 -> alarm=1 one cycle after total_out=10. Lower to 9 and 8 -> alarm stays 1. Lower to 7 -> alarm=0 (HYST=2).
- flag_clr asserted in the same cycle as a new upper-bound event on channel 3 -> ovf_flag[3] stays 1. A later lone flag_clr -> 0.
- Assert rst mid-count with total=20 and alarm=1 -> next edge: all outputs 0, thr=16. With PEAK_HOLD_EN defined: peak_out=20 before rst, 0 after, and tracks the new maximum.

Source files
------------

// File: rtl/iot_mon_pkg.sv
// Shared definitions for the multi-channel IoT device monitor:
// width helpers, alarm FSM states and counter bound-handling modes.
package iot_mon_pkg;

   localparam int MODE_WRAP = 32'sd0;
   localparam int MODE_SAT  = 32'sd1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ALARM = 1'b1
   } alarm_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 32'sd0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < n) begin
            r = i + 32'sd1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Select width never collapses to zero, even for a single channel.
   function automatic int sel_width(input int n_ch);
      int c;
      c = clog2(n_ch);
      return (c < 32'sd1) ? 32'sd1 : c;
   endfunction

endpackage

// File: rtl/iot_chan_counter.sv
// One channel's up/down device counter with wrap or saturate bound handling
// and single-cycle upper/lower bound event pulses.
module iot_chan_counter
   import iot_mon_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SAT_MODE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_change,
   input  logic             i_on_off,
   output logic [WIDTH-1:0] o_count,
   output logic             o_ovf_evt,
   output logic             o_udf_evt
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1'b1);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_at_max;
   logic             w_at_min;

   assign w_at_max  = (r_count == CNT_MAX);
   assign w_at_min  = (r_count == {WIDTH{1'b0}});
   assign o_ovf_evt = i_change &  i_on_off & w_at_max;
   assign o_udf_evt = i_change & ~i_on_off & w_at_min;

   // Next count: plain +/-1 wraps naturally; saturation pins at the bound.
   always_comb begin
      w_count_nxt = r_count;
      if (i_change) begin
         if (i_on_off) begin
            if (w_at_max && (SAT_MODE == MODE_SAT)) begin
               w_count_nxt = r_count;
            end else begin
               w_count_nxt = r_count + CNT_ONE;
            end
         end else begin
            if (w_at_min && (SAT_MODE == MODE_SAT)) begin
               w_count_nxt = r_count;
            end else begin
               w_count_nxt = r_count - CNT_ONE;
            end
         end
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= {WIDTH{1'b0}};
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/iot_monitor_multi.sv
// Multi-channel active-device monitor: per-channel counters, registered total,
// hysteretic threshold alarm, sticky bound flags and readout. Optional PEAK_HOLD_EN.
module iot_monitor_multi
   import iot_mon_pkg::*;
#(
   parameter  int N_CH     = 4,
   parameter  int WIDTH    = 8,
   parameter  int SAT_MODE = MODE_WRAP,
   parameter  int HYST     = 2,
   parameter  int THR_RST  = 16,
   localparam int SELW     = sel_width(N_CH),
   localparam int TW       = WIDTH + SELW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  i_change,
   input  logic [N_CH-1:0]  i_on_off,
   input  logic             i_thr_we,
   input  logic [TW-1:0]    i_thr_data,
   input  logic             i_flag_clr,
   input  logic [SELW-1:0]  i_rd_sel,
`ifdef PEAK_HOLD_EN
   input  logic             i_peak_clr,
   output logic [TW-1:0]    o_peak_out,
`endif
   output logic [WIDTH-1:0] o_rd_data,
   output logic [TW-1:0]    o_total_out,
   output logic             o_alarm,
   output logic [N_CH-1:0]  o_ovf_flag,
   output logic [N_CH-1:0]  o_udf_flag
);

   localparam logic [TW:0]   HYST_EXT = (TW+1)'(HYST);
   localparam logic [TW-1:0] THR_INIT = TW'(THR_RST);

   logic [WIDTH-1:0] w_count [N_CH];
   logic [N_CH-1:0]  w_ovf_evt;
   logic [N_CH-1:0]  w_udf_evt;
   logic [TW-1:0]    w_sum;
   logic [WIDTH-1:0] w_rd_mux;
   logic             w_hit;
   logic             w_clear;

   logic [TW-1:0]    r_total;
   logic [TW-1:0]    r_thr;
   logic [WIDTH-1:0] r_rd_data;
   logic [N_CH-1:0]  r_ovf_flag;
   logic [N_CH-1:0]  r_udf_flag;
   alarm_state_t     r_state;
   alarm_state_t     w_state_nxt;

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      iot_chan_counter #(
         .WIDTH    (WIDTH),
         .SAT_MODE (SAT_MODE)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .i_change  (i_change[g]),
         .i_on_off  (i_on_off[g]),
         .o_count   (w_count[g]),
         .o_ovf_evt (w_ovf_evt[g]),
         .o_udf_evt (w_udf_evt[g])
      );
   end

   // Sum and readout mux; an unmatched rd_sel leaves the mux at zero.
   always_comb begin
      w_sum    = {TW{1'b0}};
      w_rd_mux = {WIDTH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         w_sum = w_sum + TW'(w_count[i]);
         if (i_rd_sel == SELW'(i)) begin
            w_rd_mux = w_count[i];
         end else begin
            w_rd_mux = w_rd_mux;
         end
      end
   end

   // Datapath registers; a coincident bound event beats flag_clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_total    <= {TW{1'b0}};
         r_thr      <= THR_INIT;
         r_rd_data  <= {WIDTH{1'b0}};
         r_ovf_flag <= {N_CH{1'b0}};
         r_udf_flag <= {N_CH{1'b0}};
      end else begin
         r_total    <= w_sum;
         r_thr      <= i_thr_we ? i_thr_data : r_thr;
         r_rd_data  <= w_rd_mux;
         r_ovf_flag <= (r_ovf_flag & ~{N_CH{i_flag_clr}}) | w_ovf_evt;
         r_udf_flag <= (r_udf_flag & ~{N_CH{i_flag_clr}}) | w_udf_evt;
      end
   end

   // Release compare is one bit wider so total+HYST cannot wrap.
   assign w_hit   = (r_total >= r_thr);
   assign w_clear = (({1'b0, r_total} + HYST_EXT) < {1'b0, r_thr});

   // Alarm next-state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               w_state_nxt = ST_ALARM;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ALARM: begin
            if (w_clear) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_ALARM;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Alarm state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef PEAK_HOLD_EN
   logic [TW-1:0] r_peak;

   // Peak tracker follows total_out one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_peak <= {TW{1'b0}};
      end else if (i_peak_clr) begin
         r_peak <= r_total;
      end else if (r_total > r_peak) begin
         r_peak <= r_total;
      end else begin
         r_peak <= r_peak;
      end
   end

   assign o_peak_out = r_peak;
`endif

   assign o_rd_data   = r_rd_data;
   assign o_total_out = r_total;
   assign o_alarm     = (r_state == ST_ALARM);
   assign o_ovf_flag  = r_ovf_flag;
   assign o_udf_flag  = r_udf_flag;

endmodule

// File: tb/tb_iot_monitor_multi.sv
// Bench for iot_monitor_multi: a wrap-mode and a saturate-mode instance share stimulus;
// a cycle model feeds per-instance expectation queues, plus vector table and hand checks.
module tb_iot_monitor_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] change;
   logic [3:0] on_off;
   logic       thr_we;
   logic [9:0] thr_data;
   logic       flag_clr;
   logic [1:0] rd_sel;

   logic [7:0] rd_w, rd_s;
   logic [9:0] tot_w, tot_s;
   logic       al_w, al_s;
   logic [3:0] ovf_w, udf_w, ovf_s, udf_s;
`ifdef PEAK_HOLD_EN
   logic       peak_clr;
   logic [9:0] pk_w, pk_s;
`endif

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic [7:0] rd;
      logic [9:0] tot;
      logic       al;
      logic [3:0] ovf;
      logic [3:0] udf;
      logic [9:0] pk;
   } exp_t;

   exp_t exp_q_w[$];
   exp_t exp_q_s[$];

   typedef struct {
      logic [3:0] chg;
      logic [3:0] on;
      logic [1:0] sel;
      int         rd;
      int         tot;
   } vec_t;

   vec_t vecs[12];

   // model state: index 0 = wrap instance, 1 = saturate instance
   int   m_cnt[2][4];
   int   m_tot[2];
   int   m_rd[2];
   int   m_pk[2];
   bit   m_al[2];
   logic [3:0] m_ovf[2];
   logic [3:0] m_udf[2];
   int   m_thr;

   always #5 clk = ~clk;

   iot_monitor_multi #(.N_CH(4), .WIDTH(8), .SAT_MODE(0), .HYST(2), .THR_RST(16)) dut_w (
      .clk(clk), .rst(rst), .i_change(change), .i_on_off(on_off),
      .i_thr_we(thr_we), .i_thr_data(thr_data), .i_flag_clr(flag_clr), .i_rd_sel(rd_sel),
`ifdef PEAK_HOLD_EN
      .i_peak_clr(peak_clr), .o_peak_out(pk_w),
`endif
      .o_rd_data(rd_w), .o_total_out(tot_w), .o_alarm(al_w),
      .o_ovf_flag(ovf_w), .o_udf_flag(udf_w)
   );

   iot_monitor_multi #(.N_CH(4), .WIDTH(8), .SAT_MODE(1), .HYST(2), .THR_RST(16)) dut_s (
      .clk(clk), .rst(rst), .i_change(change), .i_on_off(on_off),
      .i_thr_we(thr_we), .i_thr_data(thr_data), .i_flag_clr(flag_clr), .i_rd_sel(rd_sel),
`ifdef PEAK_HOLD_EN
      .i_peak_clr(peak_clr), .o_peak_out(pk_s),
`endif
      .o_rd_data(rd_s), .o_total_out(tot_s), .o_alarm(al_s),
      .o_ovf_flag(ovf_s), .o_udf_flag(udf_s)
   );

   // Advance the model by one clock edge using the currently driven inputs, push expectations.
   task automatic model_edge();
      int   sum;
      int   old_tot;
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
            m_tot[d] = 0; m_rd[d] = 0; m_pk[d] = 0; m_al[d] = 1'b0;
            m_ovf[d] = 4'b0; m_udf[d] = 4'b0;
         end else begin
            old_tot = m_tot[d];
            sum = 0;
            for (int c = 0; c < 4; c++) sum += m_cnt[d][c];
            m_rd[d] = m_cnt[d][rd_sel];
            if (m_al[d]) m_al[d] = !((old_tot + 2) < m_thr);
            else         m_al[d] = (old_tot >= m_thr);
`ifdef PEAK_HOLD_EN
            if (peak_clr)              m_pk[d] = old_tot;
            else if (old_tot > m_pk[d]) m_pk[d] = old_tot;
`endif
            m_tot[d] = sum;
            if (flag_clr) begin
               m_ovf[d] = 4'b0;
               m_udf[d] = 4'b0;
            end
            for (int c = 0; c < 4; c++) begin
               if (change[c] && on_off[c]) begin
                  if (m_cnt[d][c] == 255) begin
                     m_ovf[d][c] = 1'b1;
                     m_cnt[d][c] = (d == 1) ? 255 : 0;
                  end else begin
                     m_cnt[d][c] = m_cnt[d][c] + 1;
                  end
               end else if (change[c]) begin
                  if (m_cnt[d][c] == 0) begin
                     m_udf[d][c] = 1'b1;
                     m_cnt[d][c] = (d == 1) ? 0 : 255;
                  end else begin
                     m_cnt[d][c] = m_cnt[d][c] - 1;
                  end
               end
            end
         end
         e.rd = 8'(m_rd[d]); e.tot = 10'(m_tot[d]); e.al = m_al[d];
         e.ovf = m_ovf[d]; e.udf = m_udf[d]; e.pk = 10'(m_pk[d]);
         if (d == 0) exp_q_w.push_back(e);
         else        exp_q_s.push_back(e);
      end
      if (rst)         m_thr = 16;
      else if (thr_we) m_thr = int'(thr_data);
   endtask

   task automatic sb_check(input int d, input logic [7:0] rd, input logic [9:0] tot,
                           input logic al, input logic [3:0] ovf, input logic [3:0] udf);
      exp_t e;
      n_total++;
      if ((d == 0 && exp_q_w.size() == 0) || (d == 1 && exp_q_s.size() == 0)) begin
         n_bad++;
         $display("FAIL sb_empty inst=%0d t=%0t", d, $time);
      end else begin
         e = (d == 0) ? exp_q_w.pop_front() : exp_q_s.pop_front();
         if (rd !== e.rd || tot !== e.tot || al !== e.al || ovf !== e.ovf || udf !== e.udf) begin
            n_bad++;
            $display("FAIL sb inst=%0d t=%0t got rd=%0d tot=%0d al=%b ovf=%b udf=%b exp rd=%0d tot=%0d al=%b ovf=%b udf=%b",
                     d, $time, rd, tot, al, ovf, udf, e.rd, e.tot, e.al, e.ovf, e.udf);
         end
`ifdef PEAK_HOLD_EN
         n_total++;
         if (((d == 0) ? pk_w : pk_s) !== e.pk) begin
            n_bad++;
            $display("FAIL sb_peak inst=%0d t=%0t got=%0d exp=%0d", d, $time,
                     (d == 0) ? pk_w : pk_s, e.pk);
         end
`endif
      end
   endtask

   // One clock: model the edge, wait past it, compare both instances.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      sb_check(0, rd_w, tot_w, al_w, ovf_w, udf_w);
      sb_check(1, rd_s, tot_s, al_s, ovf_s, udf_s);
   endtask

   task automatic idle(input logic [1:0] sel);
      change = 4'b0; on_off = 4'b0; thr_we = 1'b0; flag_clr = 1'b0; rst = 1'b0; rd_sel = sel;
`ifdef PEAK_HOLD_EN
      peak_clr = 1'b0;
`endif
   endtask

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic run_steps(input logic [3:0] chg, input logic [3:0] on, input int n);
      change = chg; on_off = on;
      for (int i = 0; i < n; i++) step();
      change = 4'b0; on_off = 4'b0;
   endtask

   initial begin
      vecs[0]  = '{4'b0011, 4'b0011, 2'd0, 0,   0};
      vecs[1]  = '{4'b0011, 4'b0011, 2'd0, 1,   2};
      vecs[2]  = '{4'b0011, 4'b0011, 2'd0, 2,   4};
      vecs[3]  = '{4'b0001, 4'b0001, 2'd0, 3,   6};
      vecs[4]  = '{4'b0001, 4'b0001, 2'd0, 4,   7};
      vecs[5]  = '{4'b0000, 4'b0000, 2'd0, 5,   8};
      vecs[6]  = '{4'b0000, 4'b0000, 2'd1, 3,   8};
      vecs[7]  = '{4'b0000, 4'b0000, 2'd2, 0,   8};
      vecs[8]  = '{4'b0100, 4'b0000, 2'd3, 0,   8};
      vecs[9]  = '{4'b0000, 4'b0000, 2'd2, 255, 263};
      vecs[10] = '{4'b0100, 4'b0100, 2'd2, 255, 263};
      vecs[11] = '{4'b0000, 4'b0000, 2'd2, 0,   8};

      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
         m_tot[d] = 0; m_rd[d] = 0; m_pk[d] = 0; m_al[d] = 1'b0;
         m_ovf[d] = 4'b0; m_udf[d] = 4'b0;
      end
      m_thr = 16;
      thr_data = 10'd0;

      // reset for two cycles
      idle(2'd0); rst = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_total", int'(tot_w), 0);
      chk("rst_alarm", int'(al_w), 0);
      chk("rst_flags", int'({ovf_w, udf_w, ovf_s, udf_s}), 0);

      // table vectors against the wrap instance
      for (int i = 0; i < 12; i++) begin
         change = vecs[i].chg; on_off = vecs[i].on; rd_sel = vecs[i].sel;
         step();
         chk($sformatf("vec%0d_rd", i), int'(rd_w), vecs[i].rd);
         chk($sformatf("vec%0d_tot", i), int'(tot_w), vecs[i].tot);
      end

      // channel 2 through the upper bound
      idle(2'd2); flag_clr = 1'b1; step(); flag_clr = 1'b0;
      run_steps(4'b0100, 4'b0100, 256);
      step();
      chk("wrap_up_cnt", int'(rd_w), 0);
      chk("sat_up_cnt", int'(rd_s), 255);
      chk("wrap_ovf", int'(ovf_w[2]), 1);
      chk("sat_ovf", int'(ovf_s[2]), 1);
      run_steps(4'b0100, 4'b0000, 1);
      step();
      chk("wrap_dn_cnt", int'(rd_w), 255);
      chk("wrap_udf", int'(udf_w[2]), 1);
      run_steps(4'b0100, 4'b0000, 300);
      step();
      chk("wrap_dn300", int'(rd_w), 211);
      chk("sat_dn_cnt", int'(rd_s), 0);
      chk("sat_udf", int'(udf_s[2]), 1);

      // threshold 10 with hysteresis 2
      idle(2'd0); rst = 1'b1; step(); rst = 1'b0;
      thr_we = 1'b1; thr_data = 10'd10; step(); thr_we = 1'b0;
      run_steps(4'b0001, 4'b0001, 10);
      step();
      chk("alm_tot10", int'(tot_w), 10);
      chk("alm_pre", int'(al_w), 0);
      step();
      chk("alm_set", int'(al_w), 1);
      for (int k = 9; k >= 7; k--) begin
         run_steps(4'b0001, 4'b0000, 1);
         step(); step();
         chk($sformatf("alm_at%0d", k), int'(al_w), (k >= 8) ? 1 : 0);
      end

      // flag_clr racing an upper-bound event on channel 3
      run_steps(4'b1000, 4'b0000, 1);
      flag_clr = 1'b1;
      run_steps(4'b1000, 4'b1000, 1);
      chk("clr_vs_set", int'(ovf_w[3]), 1);
      step();
      chk("clr_lone", int'(ovf_w[3]), 0);
      flag_clr = 1'b0;

      // mid-operation reset
      idle(2'd0); rst = 1'b1; step(); rst = 1'b0;
      run_steps(4'b0001, 4'b0001, 20);
      step(); step();
      chk("pre_rst_tot", int'(tot_w), 20);
      chk("pre_rst_alm", int'(al_w), 1);
`ifdef PEAK_HOLD_EN
      chk("pre_rst_peak", int'(pk_w), 20);
`endif
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_out", int'({rd_w, tot_w, al_w, ovf_w, udf_w}), 0);
`ifdef PEAK_HOLD_EN
      chk("mid_rst_peak", int'(pk_w), 0);
`endif
      run_steps(4'b0010, 4'b0010, 3);
      step(); step(); step();

      // random traffic, scoreboard only
      for (int i = 0; i < 400; i++) begin
         change   = 4'($urandom);
         on_off   = 4'($urandom);
         rd_sel   = 2'($urandom);
         flag_clr = ($urandom_range(0, 15) == 0);
         thr_we   = ($urandom_range(0, 31) == 0);
         thr_data = 10'($urandom_range(0, 600));
         rst      = ($urandom_range(0, 199) == 0);
`ifdef PEAK_HOLD_EN
         peak_clr = ($urandom_range(0, 31) == 0);
`endif
         step();
      end
      idle(2'd0);
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
